// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared encodings for the branch predictor: 2-bit counter
//                states, prediction status codes, init FSM states and the
//                saturating counter update helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

   // 2-bit saturating counter encodings
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Resolution status reported to fetch
   localparam logic [1:0] PSTAT_MISS_T  = 2'd0;  // predicted NT, actually T
   localparam logic [1:0] PSTAT_MISS_NT = 2'd1;  // predicted T, actually NT
   localparam logic [1:0] PSTAT_OK      = 2'd2;  // prediction correct
   localparam logic [1:0] PSTAT_NONE    = 2'd3;  // EX instruction is not a branch

   // Table initialisation FSM
   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_t;

   // Saturating counter step: taken moves toward ST, not-taken toward SNT
   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      nxt = ctr;
      case (ctr)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         default: nxt = taken ? ST  : WT;
      endcase
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor_if
//  Description : Fetch-side lookup and EX-side resolution signals of the
//                branch predictor. master = pipeline, slave = predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;

   // IF1 lookup request and IF2 control
   logic        stall;
   logic        IF2_Flush;
   logic [31:0] IF1_pc;

   // IF2 prediction results
   logic        IF2_BTBhit;
   logic [1:0]  IF2_branch_prediction;
   logic [31:0] IF2_pc_imm;
   logic        IF2_Branch;
   logic        IF2_Jump;

   // EX resolution
   logic        EX_Branch;
   logic        EX_Jump;
   logic        EX_ALUSrc;
   logic        EX_taken;
   logic [31:0] EX_pc;
   logic [31:0] EX_pc_imm;
   logic [1:0]  EX_branch_prediction;

   logic [1:0]  prediction_status;
   logic        ready;

   modport master (
      output stall, IF2_Flush, IF1_pc,
      output EX_Branch, EX_Jump, EX_ALUSrc, EX_taken, EX_pc, EX_pc_imm, EX_branch_prediction,
      input  IF2_BTBhit, IF2_branch_prediction, IF2_pc_imm, IF2_Branch, IF2_Jump,
      input  prediction_status, ready
   );

   modport slave (
      input  stall, IF2_Flush, IF1_pc,
      input  EX_Branch, EX_Jump, EX_ALUSrc, EX_taken, EX_pc, EX_pc_imm, EX_branch_prediction,
      output IF2_BTBhit, IF2_branch_prediction, IF2_pc_imm, IF2_Branch, IF2_Jump,
      output prediction_status, ready
   );

endinterface
`default_nettype wire

// File: rtl/branch_predictor_table_ram.sv
`default_nettype none
// ============================================================================
//  Module      : bp_table_ram
//  Description : Generic single-write, single synchronous-read RAM. A read
//                and write to the same address in one cycle returns the old
//                contents. rdata holds while re is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_table_ram #(
   parameter  int WIDTH  = 2,
   parameter  int DEPTH  = 256,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and read-before-write registered read port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped PHT of 2-bit counters plus direct-mapped BTB.
//                IF1 PC lookup returns counter/hit/target/type in IF2 one
//                cycle later; EX resolution trains both tables and reports
//                prediction_status. Tables are initialised after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
   import bp_pkg::*;
#(
   parameter int PHT_ENTRIES = 256,
   parameter int BTB_ENTRIES = 64
) (
   input  logic              clk,
   input  logic              rst,
   branch_predictor_if.slave bus
);

   localparam int PHT_IDX_W  = $clog2(PHT_ENTRIES);
   localparam int BTB_IDX_W  = $clog2(BTB_ENTRIES);
   localparam int TAG_W      = 32 - BTB_IDX_W - 2;
   localparam int BTB_W      = TAG_W + 32 + 2;
   localparam int INIT_DEPTH = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
   localparam int INIT_W     = $clog2(INIT_DEPTH);

   // ------------------------------------------------------------------------
   // Init FSM state
   // ------------------------------------------------------------------------
   bp_state_t         r_state;
   logic [INIT_W-1:0] r_init_idx;
   logic              r_ready;
   logic              w_run;
   logic              w_init;
   logic              w_init_pht_we;
   logic              w_init_btb_clr;

   assign w_run  = (r_state == ST_RUN);
   assign w_init = (r_state == ST_INIT);
   assign w_init_pht_we  = w_init && ({1'b0, r_init_idx} < (INIT_W+1)'(PHT_ENTRIES));
   assign w_init_btb_clr = w_init && ({1'b0, r_init_idx} < (INIT_W+1)'(BTB_ENTRIES));

   // Sweep every table index once after reset, then enter RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_init_idx <= '0;
         r_ready    <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_init_idx <= r_init_idx + 1'b1;
               if (r_init_idx == INIT_W'(INIT_DEPTH - 1)) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign bus.ready = r_ready;

   // ------------------------------------------------------------------------
   // Index / tag extraction
   // ------------------------------------------------------------------------
   logic [PHT_IDX_W-1:0] w_if_pht_idx;
   logic [BTB_IDX_W-1:0] w_if_btb_idx;
   logic [TAG_W-1:0]     w_if_tag;
   logic [PHT_IDX_W-1:0] w_ex_pht_idx;
   logic [BTB_IDX_W-1:0] w_ex_btb_idx;
   logic [TAG_W-1:0]     w_ex_tag;
   logic                 w_unused;

   assign w_if_pht_idx = bus.IF1_pc[PHT_IDX_W+1:2];
   assign w_if_btb_idx = bus.IF1_pc[BTB_IDX_W+1:2];
   assign w_if_tag     = bus.IF1_pc[31:BTB_IDX_W+2];
   assign w_ex_pht_idx = bus.EX_pc[PHT_IDX_W+1:2];
   assign w_ex_btb_idx = bus.EX_pc[BTB_IDX_W+1:2];
   assign w_ex_tag     = bus.EX_pc[31:BTB_IDX_W+2];

   // Byte-offset bits and the counter LSB carry no prediction information
   assign w_unused = ^{bus.IF1_pc[1:0], bus.EX_pc[1:0], bus.EX_branch_prediction[0]};

   // ------------------------------------------------------------------------
   // PHT: two identically-written copies. One serves IF1 lookups, the other
   // reads the counter of the EX branch so training is a read-modify-write
   // that lands one cycle after EX.
   // ------------------------------------------------------------------------
   logic                 w_pht_we;
   logic [PHT_IDX_W-1:0] w_pht_waddr;
   logic [1:0]           w_pht_wdata;
   logic [1:0]           w_pht_if_rdata;
   logic [1:0]           w_pht_ex_rdata;

   logic                 r_upd_vld;
   logic [PHT_IDX_W-1:0] r_upd_idx;
   logic                 r_upd_taken;
   logic                 r_prev_vld;
   logic [PHT_IDX_W-1:0] r_prev_idx;
   logic [1:0]           r_prev_val;
   logic [1:0]           w_upd_base;
   logic [1:0]           w_upd_next;

   // Back-to-back updates to one index: the RAM read missed the previous
   // write, so take the counter from the write just committed
   assign w_upd_base = (r_prev_vld && (r_prev_idx == r_upd_idx)) ? r_prev_val : w_pht_ex_rdata;
   assign w_upd_next = sat_update(w_upd_base, r_upd_taken);

   // PHT write port: init sweep has priority over training
   always_comb begin
      w_pht_we    = 1'b0;
      w_pht_waddr = r_upd_idx;
      w_pht_wdata = w_upd_next;
      if (w_init) begin
         w_pht_we    = w_init_pht_we;
         w_pht_waddr = r_init_idx[PHT_IDX_W-1:0];
         w_pht_wdata = WNT;
      end else if (r_upd_vld) begin
         w_pht_we = 1'b1;
      end
   end

   // Training pipeline: capture EX branch, then remember the committed write
   always_ff @(posedge clk) begin
      if (rst) begin
         r_upd_vld  <= 1'b0;
         r_prev_vld <= 1'b0;
      end else begin
         r_upd_vld  <= w_run && bus.EX_Branch;
         r_prev_vld <= w_run && r_upd_vld;
      end
      r_upd_idx   <= w_ex_pht_idx;
      r_upd_taken <= bus.EX_taken;
      r_prev_idx  <= r_upd_idx;
      r_prev_val  <= w_upd_next;
   end

   bp_table_ram #(.WIDTH(2), .DEPTH(PHT_ENTRIES)) u_pht_if (
      .clk   (clk),
      .we    (w_pht_we),
      .waddr (w_pht_waddr),
      .wdata (w_pht_wdata),
      .re    (!bus.stall),
      .raddr (w_if_pht_idx),
      .rdata (w_pht_if_rdata)
   );

   bp_table_ram #(.WIDTH(2), .DEPTH(PHT_ENTRIES)) u_pht_ex (
      .clk   (clk),
      .we    (w_pht_we),
      .waddr (w_pht_waddr),
      .wdata (w_pht_wdata),
      .re    (1'b1),
      .raddr (w_ex_pht_idx),
      .rdata (w_pht_ex_rdata)
   );

   // ------------------------------------------------------------------------
   // BTB: tag/target/type in RAM, valid bits in flops
   // ------------------------------------------------------------------------
   logic [BTB_ENTRIES-1:0] r_btb_valid;
   logic                   w_btb_we;
   logic [BTB_W-1:0]       w_btb_wdata;
   logic [BTB_W-1:0]       w_btb_rdata;
   logic [TAG_W-1:0]       w_btb_rtag;
   logic [31:0]            w_btb_rtarget;
   logic                   w_btb_rbranch;
   logic                   w_btb_rjump;

   // Allocate on taken branches and direct jumps; JALR targets are not cached
   assign w_btb_we    = w_run && ((bus.EX_Branch && bus.EX_taken) || (bus.EX_Jump && !bus.EX_ALUSrc));
   assign w_btb_wdata = {w_ex_tag, bus.EX_pc_imm, bus.EX_Branch, bus.EX_Jump};
   assign {w_btb_rtag, w_btb_rtarget, w_btb_rbranch, w_btb_rjump} = w_btb_rdata;

   // Valid bits: cleared by the init sweep, set on allocation
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btb_valid <= '0;
      end else if (w_init) begin
         if (w_init_btb_clr) begin
            r_btb_valid[r_init_idx[BTB_IDX_W-1:0]] <= 1'b0;
         end
      end else if (w_btb_we) begin
         r_btb_valid[w_ex_btb_idx] <= 1'b1;
      end
   end

   bp_table_ram #(.WIDTH(BTB_W), .DEPTH(BTB_ENTRIES)) u_btb (
      .clk   (clk),
      .we    (w_btb_we),
      .waddr (w_ex_btb_idx),
      .wdata (w_btb_wdata),
      .re    (!bus.stall),
      .raddr (w_if_btb_idx),
      .rdata (w_btb_rdata)
   );

   // ------------------------------------------------------------------------
   // IF2 stage: r_if2_live marks a real lookup; without it every output
   // shows the miss values (reset, INIT and flush bubbles)
   // ------------------------------------------------------------------------
   logic             r_if2_live;
   logic             r_if2_valid;
   logic [TAG_W-1:0] r_if2_tag;
   logic             w_hit;

   // IF1->IF2 register: flush beats stall, stall beats a new lookup
   always_ff @(posedge clk) begin
      if (rst) begin
         r_if2_live  <= 1'b0;
         r_if2_valid <= 1'b0;
         r_if2_tag   <= '0;
      end else begin
         if (bus.IF2_Flush) begin
            r_if2_live <= 1'b0;
         end else if (!bus.stall) begin
            r_if2_live <= w_run;
         end
         if (!bus.stall) begin
            r_if2_valid <= r_btb_valid[w_if_btb_idx];
            r_if2_tag   <= w_if_tag;
         end
      end
   end

   assign w_hit = r_if2_live && r_if2_valid && (w_btb_rtag == r_if2_tag);

   assign bus.IF2_BTBhit            = w_hit;
   assign bus.IF2_branch_prediction = r_if2_live ? w_pht_if_rdata : WNT;
   assign bus.IF2_pc_imm            = w_hit ? w_btb_rtarget : 32'h0;
   assign bus.IF2_Branch            = w_hit && w_btb_rbranch;
   assign bus.IF2_Jump              = w_hit && w_btb_rjump;

   // ------------------------------------------------------------------------
   // Resolution status for fetch redirect / flush
   // ------------------------------------------------------------------------
   logic [1:0] w_pstat;

   // Compare predicted direction (counter MSB) with the resolved direction
   always_comb begin
      w_pstat = PSTAT_NONE;
      if (bus.EX_Branch) begin
         if (bus.EX_branch_prediction[1] == bus.EX_taken) begin
            w_pstat = PSTAT_OK;
         end else if (bus.EX_taken) begin
            w_pstat = PSTAT_MISS_T;
         end else begin
            w_pstat = PSTAT_MISS_NT;
         end
      end
   end

   assign bus.prediction_status = w_pstat;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Directed scoreboard bench. Stimulus pushes expected IF2
//                lookup results and same-cycle status/ready values into
//                queues; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   branch_predictor_if bus_if ();

   branch_predictor #(.PHT_ENTRIES(256), .BTB_ENTRIES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      string       name;
      int          kind;   // 0 = lookup, 1 = prediction_status, 2 = ready
      logic [36:0] val;
      logic [36:0] mask;
   } exp_t;

   exp_t q_look[$];
   exp_t q_now[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic look_req = 1'b0;
   logic now_req  = 1'b0;
   logic look_d   = 1'b0;

   localparam logic [36:0] ALL  = {37{1'b1}};
   localparam logic [36:0] NOPR = {1'b1, 2'b00, {34{1'b1}}};

   function automatic logic [36:0] pk(input logic hit, input logic [1:0] pred,
                                      input logic [31:0] tgt, input logic br, input logic jmp);
      return {hit, pred, tgt, br, jmp};
   endfunction

   task automatic cmp(input string nm, input logic [36:0] act, input logic [36:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: IF2 results are compared the cycle after the lookup was issued
   always @(posedge clk) look_d <= look_req;

   always @(negedge clk) begin
      exp_t        e;
      logic [36:0] act;
      if (look_d) begin
         if (q_look.size() == 0) begin
            cmp("lookup_queue_empty", 37'd1, 37'd0);
         end else begin
            e   = q_look.pop_front();
            act = pk(bus_if.IF2_BTBhit, bus_if.IF2_branch_prediction, bus_if.IF2_pc_imm,
                     bus_if.IF2_Branch, bus_if.IF2_Jump);
            cmp(e.name, act & e.mask, e.val & e.mask);
         end
      end
      if (now_req) begin
         if (q_now.size() == 0) begin
            cmp("now_queue_empty", 37'd1, 37'd0);
         end else begin
            e = q_now.pop_front();
            if (e.kind == 1) act = {35'd0, bus_if.prediction_status};
            else             act = {36'd0, bus_if.ready};
            cmp(e.name, act, e.val);
         end
      end
   end

   // One stimulus slot: inputs change 1 time unit after the rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
      look_req             = 1'b0;
      now_req              = 1'b0;
      bus_if.stall         = 1'b0;
      bus_if.IF2_Flush     = 1'b0;
      bus_if.EX_Branch     = 1'b0;
      bus_if.EX_Jump       = 1'b0;
      bus_if.EX_ALUSrc     = 1'b0;
      bus_if.EX_taken      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic look_m(input string nm, input logic [31:0] pc, input logic st, input logic fl,
                         input logic [36:0] v, input logic [36:0] m);
      cyc();
      bus_if.stall     = st;
      bus_if.IF2_Flush = fl;
      bus_if.IF1_pc    = pc;
      look_req         = 1'b1;
      q_look.push_back('{name: nm, kind: 0, val: v, mask: m});
   endtask

   task automatic look(input string nm, input logic [31:0] pc, input logic [36:0] v);
      look_m(nm, pc, 1'b0, 1'b0, v, ALL);
   endtask

   task automatic ex(input logic br, input logic jmp, input logic alu, input logic tk,
                     input logic [31:0] pc, input logic [31:0] imm, input logic [1:0] bp);
      cyc();
      bus_if.EX_Branch            = br;
      bus_if.EX_Jump              = jmp;
      bus_if.EX_ALUSrc            = alu;
      bus_if.EX_taken             = tk;
      bus_if.EX_pc                = pc;
      bus_if.EX_pc_imm            = imm;
      bus_if.EX_branch_prediction = bp;
   endtask

   task automatic ex_stat(input string nm, input logic br, input logic tk,
                          input logic [1:0] bp, input logic [1:0] exp_stat);
      ex(br, 1'b0, 1'b0, tk, 32'h300, 32'h400, bp);
      now_req = 1'b1;
      q_now.push_back('{name: nm, kind: 1, val: {35'd0, exp_stat}, mask: ALL});
   endtask

   task automatic push_ready(input string nm, input logic r);
      now_req = 1'b1;
      q_now.push_back('{name: nm, kind: 2, val: {36'd0, r}, mask: ALL});
   endtask

   // Bounded wait for ready; the slot count must be exactly the init length
   task automatic wait_ready(input string nm);
      int cnt;
      cnt = 400;
      for (int k = 1; k <= 400; k++) begin
         cyc();
         if (bus_if.ready === 1'b1) begin
            cnt = k;
            break;
         end
      end
      cmp(nm, 37'(cnt), 37'd256);
   endtask

   initial begin
      bus_if.stall                = 1'b0;
      bus_if.IF2_Flush            = 1'b0;
      bus_if.IF1_pc               = 32'h0;
      bus_if.EX_Branch            = 1'b0;
      bus_if.EX_Jump              = 1'b0;
      bus_if.EX_ALUSrc            = 1'b0;
      bus_if.EX_taken             = 1'b0;
      bus_if.EX_pc                = 32'h0;
      bus_if.EX_pc_imm            = 32'h0;
      bus_if.EX_branch_prediction = 2'b00;

      // 1. Reset, INIT lookup and init length
      rst = 1'b1;
      idle(3);
      rst           = 1'b0;
      bus_if.IF1_pc = 32'h100;
      look_req      = 1'b1;
      q_look.push_back('{name: "init_lookup_0x100", kind: 0, val: pk(0, 2'b01, 0, 0, 0), mask: ALL});
      push_ready("ready_after_reset", 1'b0);
      wait_ready("init_latency");

      // 2. Counter training at 0x40 (second pair of NTs is back-to-back)
      ex(1, 0, 0, 1, 32'h40, 32'h140, 2'b01); idle(2);
      look("pht_t1_10", 32'h40, pk(1, 2'b10, 32'h140, 1, 0));
      ex(1, 0, 0, 1, 32'h40, 32'h140, 2'b10); idle(2);
      look("pht_t2_11", 32'h40, pk(1, 2'b11, 32'h140, 1, 0));
      ex(1, 0, 0, 0, 32'h40, 32'h140, 2'b11);
      ex(1, 0, 0, 0, 32'h40, 32'h140, 2'b10); idle(2);
      look("pht_nt2_01", 32'h40, pk(1, 2'b01, 32'h140, 1, 0));
      ex(1, 0, 0, 0, 32'h40, 32'h140, 2'b01); idle(2);
      look("pht_nt3_00", 32'h40, pk(1, 2'b00, 32'h140, 1, 0));
      ex(1, 0, 0, 0, 32'h40, 32'h140, 2'b00); idle(2);
      look("pht_nt4_hold_00", 32'h40, pk(1, 2'b00, 32'h140, 1, 0));

      // 3. JAL allocates, JALR does not
      ex(0, 1, 0, 1, 32'h80, 32'h200, 2'b01);
      ex(0, 1, 1, 1, 32'h84, 32'h300, 2'b01); idle(2);
      look("jal_hit_0x80", 32'h80, pk(1, 2'b01, 32'h200, 0, 1));
      look("jalr_miss_0x84", 32'h84, pk(0, 2'b01, 32'h0, 0, 0));

      // 4. Aliasing: same BTB and PHT index, different tag
      ex(1, 0, 0, 1, 32'h1040, 32'h2000, 2'b00); idle(2);
      look("alias_old_miss_0x40", 32'h40, pk(0, 2'b01, 32'h0, 0, 0));
      look("alias_new_hit_0x1040", 32'h1040, pk(1, 2'b01, 32'h2000, 1, 0));

      // 5. Stall holds IF2, flush forces a bubble even under stall
      look("stall_pre_0x80", 32'h80, pk(1, 2'b01, 32'h200, 0, 1));
      look_m("stall_c1", 32'h1040, 1'b1, 1'b0, pk(1, 2'b01, 32'h200, 0, 1), ALL);
      look_m("stall_c2", 32'h84,   1'b1, 1'b0, pk(1, 2'b01, 32'h200, 0, 1), ALL);
      look_m("stall_c3", 32'h0,    1'b1, 1'b0, pk(1, 2'b01, 32'h200, 0, 1), ALL);
      look_m("flush_with_stall", 32'h1040, 1'b1, 1'b1, pk(0, 2'b00, 32'h0, 0, 0), NOPR);
      look("after_flush_0x1040", 32'h1040, pk(1, 2'b01, 32'h2000, 1, 0));

      // 6. prediction_status encodings
      ex_stat("stat_pred_t_act_nt", 1'b1, 1'b0, 2'b10, 2'd1);
      ex_stat("stat_pred_nt_act_t", 1'b1, 1'b1, 2'b01, 2'd0);
      ex_stat("stat_correct_t",     1'b1, 1'b1, 2'b11, 2'd2);
      ex_stat("stat_not_branch",    1'b0, 1'b1, 2'b10, 2'd3);

      // rst in RUN restarts initialisation and clears both tables
      cyc();
      rst = 1'b1;
      cyc();
      rst           = 1'b0;
      push_ready("ready_low_after_rerst", 1'b0);
      bus_if.IF1_pc = 32'h80;
      look_req      = 1'b1;
      q_look.push_back('{name: "rerst_init_lookup", kind: 0, val: pk(0, 2'b01, 0, 0, 0), mask: ALL});
      wait_ready("reinit_latency");
      look("rerst_btb_cleared_0x80", 32'h80, pk(0, 2'b01, 32'h0, 0, 0));
      look("rerst_pht_cleared_0x40", 32'h40, pk(0, 2'b01, 32'h0, 0, 0));

      idle(3);
      cmp("queues_drained", 37'(q_look.size() + q_now.size()), 37'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog timeout");
   end

endmodule
`default_nettype wire
